instr_window: RTL

- Byte-queue stage directly upstream of the combinational instruction decoder.
- Accepts 32-bit little-endian words of instruction stream from the trace feeder over a valid/ready handshake.
- Presents a 96-bit raw_instr window to the decoder, aligned to the current instruction start.
- Drops consumed bytes when the step logic returns the decoder's instr_len.

---
 rtl/instr_window_if.sv | 28 ++
 rtl/instr_window.sv | 92 +++++++++
 2 files changed

// File: rtl/instr_window_if.sv
// Handshake and window bundle between the trace feeder, the instruction
// window and the decoder/step logic. Feeder side: in_valid/in_ready/in_data/
// in_last/flush. Decoder side: out_valid/raw_instr/out_count/advance/
// advance_len/consumed/err. master = feeder+step logic, slave = instr_window.
interface instr_window_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        flush;
  logic        out_valid;
  logic [95:0] raw_instr;
  logic [4:0]  out_count;
  logic        advance;
  logic [3:0]  advance_len;
  logic [31:0] consumed;
  logic        err;

  modport master (
    output in_valid, in_data, in_last, flush, advance, advance_len,
    input  in_ready, out_valid, raw_instr, out_count, consumed, err
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, advance, advance_len,
    output in_ready, out_valid, raw_instr, out_count, consumed, err
  );
endinterface

// File: rtl/instr_window.sv
// Byte queue feeding a 96-bit aligned instruction window to the decoder.
// Latency: accepted word / advance visible on raw_instr and out_count next cycle.
// Backpressure: in_ready drops when fewer than 4 free bytes or after end of stream.
// Ports: clk, rst (sync, active-high); bus (instr_window_if.slave) carries the
// feeder word handshake, flush, the window outputs and the advance/consumed/err
// step interface. DEPTH is the byte capacity, 16 or 20.
module instr_window #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  instr_window_if.slave  bus
);

  localparam int WIN = 12;

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [4:0]  count_q;
  logic        eos_q;
  logic        err_q;
  logic [31:0] consumed_q;

  logic        adv_ok;
  logic        push;
  logic [4:0]  base;
  logic [95:0] window;

  // Both depend only on registered state, so the feeder never sees a
  // combinational path from advance.
  assign bus.in_ready  = !eos_q && (count_q <= 5'(DEPTH - 4));
  assign bus.out_valid = (count_q >= 5'(WIN)) || (eos_q && (count_q != 5'd0));

  assign adv_ok = bus.advance && bus.out_valid &&
                  (bus.advance_len != 4'd0) && (bus.advance_len <= 4'd12) &&
                  ({1'b0, bus.advance_len} <= count_q);
  assign push   = bus.in_valid && bus.in_ready;

  // Append position after any same-cycle shift.
  assign base = count_q - (adv_ok ? {1'b0, bus.advance_len} : 5'd0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (adv_ok) begin
        mem_d[i] = ((i + int'(bus.advance_len)) < DEPTH) ?
                   mem_q[i + int'(bus.advance_len)] : 8'h00;
      end
    end
    // base + 3 stays inside the array: a push needs count <= DEPTH-4.
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        mem_d[int'(base) + k] = bus.in_data[8*k +: 8];
      end
    end
  end

  // Bytes beyond count are stale; mask them so the decoder sees zeros.
  always_comb begin
    window = '0;
    for (int i = 0; i < WIN; i++) begin
      window[8*i +: 8] = (5'(i) < count_q) ? mem_q[i] : 8'h00;
    end
  end

  assign bus.raw_instr = window;
  assign bus.out_count = count_q;
  assign bus.consumed  = consumed_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 5'd0;
      eos_q      <= 1'b0;
      err_q      <= 1'b0;
      consumed_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (bus.flush) begin
      // A redirect discards the stream but keeps the consumed tally.
      count_q <= 5'd0;
      eos_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.advance && !adv_ok) err_q <= 1'b1;
      if (adv_ok) consumed_q <= consumed_q + {28'd0, bus.advance_len};
      if (push && bus.in_last) eos_q <= 1'b1;
      count_q <= base + (push ? 5'd4 : 5'd0);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
